// File: rtl/i2s_audio_receiver_pkg.sv
// Audio Pmod shared definitions: sample widths, divider taps, stereo types.
// Used by the I2S receiver and the speaker controller.
package i2s_audio_receiver_pkg;

  localparam int AUDIO_DW         = 16;
  localparam int SCK_DIV_LOG2_DEF = 3;
  localparam int MCLK_BIT         = 1;

  function automatic int lrck_bit_f(
    input int dw,
    input int sck_log2
  );
    return sck_log2 + 1 + $clog2(dw);
  endfunction

  localparam int LRCK_BIT_DEF =
    lrck_bit_f(AUDIO_DW, SCK_DIV_LOG2_DEF);

  typedef logic signed [AUDIO_DW-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

endpackage

// File: rtl/i2s_clock_divider.sv
// Codec clock divider: mclk/sck/lrck taps, data capture strobe, slot index.
// Shared between the I2S receiver and the speaker controller.
module i2s_clock_divider
  import i2s_audio_receiver_pkg::*;
#(
  parameter int SCK_DIV_LOG2 = SCK_DIV_LOG2_DEF,
  parameter int LRCK_BIT     = LRCK_BIT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_mclk,
  output logic o_sck,
  output logic o_lrck,
  output logic o_capture,
  output logic [LRCK_BIT-SCK_DIV_LOG2-2:0] o_slot
);

  localparam int PH_W = SCK_DIV_LOG2 + 1;
  // two clk after sck rises gives the synchroniser time to settle
  localparam logic [PH_W-1:0] CAP_PHASE =
    PH_W'((1 << SCK_DIV_LOG2) + 2);

  logic [LRCK_BIT:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_mclk    = r_cnt[MCLK_BIT];
  assign o_sck     = r_cnt[SCK_DIV_LOG2];
  assign o_lrck    = r_cnt[LRCK_BIT];
  assign o_slot    = r_cnt[LRCK_BIT-1:PH_W];
  assign o_capture = i_en &&
    (r_cnt[PH_W-1:0] == CAP_PHASE);

endmodule

// File: rtl/i2s_audio_receiver.sv
// I2S master receiver: drives codec clocks, deserialises the ADC stream
// and hands out one stereo pair per frame over valid/ready.
module i2s_audio_receiver
  import i2s_audio_receiver_pkg::*;
#(
  parameter int DATA_WIDTH   = AUDIO_DW,
  parameter int SCK_DIV_LOG2 = SCK_DIV_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  audio_sdout,
  output logic                  audio_mclk,
  output logic                  audio_sck,
  output logic                  audio_lrck,
  output logic [DATA_WIDTH-1:0] sample_left,
  output logic [DATA_WIDTH-1:0] sample_right,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun
);

  localparam int SLOT_W   = $clog2(DATA_WIDTH);
  localparam int LRCK_BIT = SCK_DIV_LOG2 + 1 + SLOT_W;

  logic              w_capture;
  logic              w_lrck;
  logic [SLOT_W-1:0] w_slot;

  i2s_clock_divider #(
    .SCK_DIV_LOG2 (SCK_DIV_LOG2),
    .LRCK_BIT     (LRCK_BIT)
  ) u_div (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .o_mclk    (audio_mclk),
    .o_sck     (audio_sck),
    .o_lrck    (w_lrck),
    .o_capture (w_capture),
    .o_slot    (w_slot)
  );

  assign audio_lrck = w_lrck;

  logic r_sd_meta;
  logic r_sd_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sd_meta <= 1'b0;
      r_sd_s    <= 1'b0;
    end else begin
      r_sd_meta <= audio_sdout;
      r_sd_s    <= r_sd_meta;
    end
  end

  logic [DATA_WIDTH-2:0] r_shift;
  logic [DATA_WIDTH-1:0] r_left_stage;
  logic                  r_left_ok;
  logic [DATA_WIDTH-1:0] w_word;
  chan_e                 w_chan;
  logic                  w_slot0;
  logic                  w_left_done;
  logic                  w_pair_done;

  // slot 0 carries the LSB of the channel that just ended
  assign w_word      = {r_shift, r_sd_s};
  assign w_chan      = chan_e'(w_lrck);
  assign w_slot0     = (w_slot == '0);
  assign w_left_done = w_capture && w_slot0 &&
                       (w_chan == CH_RIGHT);
  assign w_pair_done = w_capture && w_slot0 &&
                       (w_chan == CH_LEFT) && r_left_ok;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_shift      <= '0;
      r_left_stage <= '0;
      r_left_ok    <= 1'b0;
    end else if (w_capture) begin
      r_shift <= w_word[DATA_WIDTH-2:0];
      if (w_left_done) begin
        r_left_stage <= w_word;
        r_left_ok    <= 1'b1;
      end
    end
  end

  logic [DATA_WIDTH-1:0] r_left;
  logic [DATA_WIDTH-1:0] r_right;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  w_accept;
  logic                  w_blocked;

  assign w_accept  = r_valid && sample_ready;
  assign w_blocked = r_valid && !sample_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_left    <= '0;
      r_right   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_pair_done && !w_blocked) begin
      r_left  <= r_left_stage;
      r_right <= w_word;
      r_valid <= 1'b1;
    end else if (w_pair_done) begin
      r_overrun <= 1'b1;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign sample_left  = r_left;
  assign sample_right = r_right;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_i2s_audio_receiver.sv
// Bench for i2s_audio_receiver: I2S ADC model feeding a scoreboard that is
// drained by an output monitor on every accepted pair.
module tb_i2s_audio_receiver;
  import i2s_audio_receiver_pkg::*;

  logic        clk          = 1'b0;
  logic        rst          = 1'b1;
  logic        en           = 1'b1;
  logic        audio_sdout  = 1'b0;
  logic        sample_ready = 1'b1;
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        sample_valid;
  logic        overrun;
  logic [15:0] sample_left;
  logic [15:0] sample_right;

  i2s_audio_receiver dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .audio_sdout  (audio_sdout),
    .audio_mclk   (audio_mclk),
    .audio_sck    (audio_sck),
    .audio_lrck   (audio_lrck),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rel();
    return cyc - t0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  stereo_t sb[$];

  // ADC model: changes data on sck fall, one-bit delay after lrck edge
  logic [15:0] cur_l  = 16'h0;
  logic [15:0] cur_r  = 16'h0;
  logic [15:0] nxt_l  = 16'hA5C3;
  logic [15:0] nxt_r  = 16'h3C5A;
  bit          alt    = 1'b0;
  bit          alt_ph = 1'b0;
  bit          lok    = 1'b0;
  int          slot   = 0;
  logic        p_sck  = 1'b0;
  logic        p_lrck = 1'b0;

  always @(posedge clk) begin
    #2;
    if (rst || !en) begin
      slot        = 0;
      lok         = 1'b0;
      alt_ph      = 1'b0;
      cur_l       = nxt_l;
      cur_r       = nxt_r;
      audio_sdout = 1'b0;
    end else if (audio_lrck !== p_lrck) begin
      slot = 0;
      if (audio_lrck) begin
        audio_sdout = cur_l[0];
        lok         = 1'b1;
      end else begin
        audio_sdout = cur_r[0];
        if (lok) sb.push_back(stereo_t'({cur_l, cur_r}));
        if (alt) begin
          cur_l  = alt_ph ? 16'h0001 : 16'hFFFF;
          cur_r  = alt_ph ? 16'hFFFF : 16'h0001;
          alt_ph = !alt_ph;
        end else begin
          cur_l = nxt_l;
          cur_r = nxt_r;
        end
      end
    end else if (!audio_sck && p_sck) begin
      slot++;
      if (slot < 16)
        audio_sdout = audio_lrck ? cur_r[16-slot]
                                 : cur_l[16-slot];
      else
        audio_sdout = 1'b0;
    end
    p_sck  = audio_sck;
    p_lrck = audio_lrck;
  end

  int          acc_cnt = 0;
  int          acc_rel = 0;
  logic [15:0] last_l  = 16'h0;
  logic [15:0] last_r  = 16'h0;
  stereo_t     mon_e;
  int          mclk_per = 0;
  int          sck_per  = 0;
  int          lrck_per = 0;
  int          mclk_lst = 0;
  int          sck_lst  = 0;
  int          lrck_lst = 0;
  logic        pm = 1'b0;
  logic        ps = 1'b0;
  logic        pl = 1'b0;

  always @(negedge clk) begin
    if (!rst && sample_valid && sample_ready) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("pair_left", {16'd0, sample_left},
            {16'd0, mon_e.left});
        chk("pair_right", {16'd0, sample_right},
            {16'd0, mon_e.right});
      end
      last_l = sample_left;
      last_r = sample_right;
      acc_cnt++;
      acc_rel = cyc - t0;
    end
    if (audio_mclk && !pm) begin
      mclk_per = cyc - mclk_lst;
      mclk_lst = cyc;
    end
    if (audio_sck && !ps) begin
      sck_per = cyc - sck_lst;
      sck_lst = cyc;
    end
    if (audio_lrck && !pl) begin
      lrck_per = cyc - lrck_lst;
      lrck_lst = cyc;
    end
    pm = audio_mclk;
    ps = audio_sck;
    pl = audio_lrck;
  end

  task automatic wait_acc(
    input int    target,
    input int    limit,
    input string tag
  );
    while (acc_cnt < target && rel() < limit) step();
    chk({tag, "_seen"}, 32'(acc_cnt >= target), 32'd1);
  endtask

  logic [2:0] clks;
  logic       frozen;
  int         base;

  assign clks = {audio_mclk, audio_sck, audio_lrck};

  initial begin
    repeat (4) step();
    chk("rst_valid",  32'(sample_valid), 32'd0);
    chk("rst_left",   32'(sample_left),  32'd0);
    chk("rst_right",  32'(sample_right), 32'd0);
    chk("rst_ovr",    32'(overrun),      32'd0);
    chk("rst_clocks", 32'(clks),         32'd0);

    rst = 1'b0;
    t0  = cyc;
    while (acc_cnt < 1 && rel() < 700) begin
      if (rel() == 255)
        chk("lrck_low_255", 32'(audio_lrck), 32'd0);
      if (rel() == 256)
        chk("lrck_high_256", 32'(audio_lrck), 32'd1);
      step();
    end
    chk("first_seen", 32'(acc_cnt), 32'd1);
    chk("first_valid_cyc", acc_rel, 523);
    wait_acc(2, 1200, "second");
    chk("second_valid_cyc", acc_rel, 1035);
    chk("mclk_period", mclk_per, 4);
    chk("sck_period",  sck_per,  16);
    chk("lrck_period", lrck_per, 512);

    nxt_l = 16'h8000;
    nxt_r = 16'h7FFF;
    wait_acc(4, 2200, "ext");
    chk("ext_left_min",  32'($signed(last_l)), 32'(-32768));
    chk("ext_right_max", 32'($signed(last_r)), 32'(32767));

    alt = 1'b1;
    wait_acc(8, 4300, "alt");

    sample_ready = 1'b0;
    while (!overrun && rel() < 5400) step();
    chk("ovr_set",     32'(overrun),      32'd1);
    chk("ovr_cyc",     rel(),             5131);
    chk("ovr_valid",   32'(sample_valid), 32'd1);
    chk("ovr_sb_deep", sb.size(),         2);
    chk("held_left", {16'd0, sample_left}, {16'd0, sb[0].left});
    sample_ready = 1'b1;
    step();
    chk("drain_one", 32'(sample_valid), 32'd0);
    chk("drain_cnt", acc_cnt, 9);
    if (sb.size() > 0) void'(sb.pop_front());
    wait_acc(10, 5800, "post_ovr");
    chk("ovr_sticky", 32'(overrun), 32'd1);

    alt   = 1'b0;
    nxt_l = 16'h1234;
    nxt_r = 16'hFEDC;
    rst   = 1'b1;
    step();
    sb.delete();
    step();
    step();
    chk("rst2_ovr",   32'(overrun),      32'd0);
    chk("rst2_valid", 32'(sample_valid), 32'd0);
    chk("rst2_left",  32'(sample_left),  32'd0);
    rst = 1'b0;
    t0  = cyc;
    while (rel() < 300) step();
    nxt_l = 16'h0F0F;
    nxt_r = 16'hF0F0;
    rst   = 1'b1;
    step();
    step();
    chk("midrst_valid",  32'(sample_valid), 32'd0);
    chk("midrst_clocks", 32'(clks),         32'd0);
    sb.delete();
    step();
    rst  = 1'b0;
    t0   = cyc;
    base = acc_cnt;
    wait_acc(base + 1, 700, "post_rst");
    chk("post_rst_cyc", acc_rel, 523);

    sample_ready = 1'b0;
    while (rel() < 1100) step();
    chk("pre_en_held", 32'(sample_valid), 32'd1);
    en    = 1'b0;
    nxt_l = 16'h5A5A;
    nxt_r = 16'hC3C3;
    step();
    step();
    frozen = 1'b0;
    repeat (998) begin
      frozen = frozen | (|clks);
      step();
    end
    chk("en_clk_frozen", 32'(frozen),       32'd0);
    chk("en_held_valid", 32'(sample_valid), 32'd1);
    chk("en_held_left", {16'd0, sample_left}, {16'd0, sb[0].left});
    chk("en_held_right", {16'd0, sample_right}, {16'd0, sb[0].right});
    chk("en_ovr", 32'(overrun), 32'd0);
    en = 1'b1;
    t0 = cyc;
    while (rel() < 522) step();
    sample_ready = 1'b1;
    step();
    chk("coinc_valid", 32'(sample_valid), 32'd1);
    chk("coinc_ovr",   32'(overrun),      32'd0);
    step();
    chk("restart_cyc",  acc_rel,           523);
    chk("sb_empty_end", sb.size(),         0);
    chk("final_drain",  32'(sample_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
